// File: rtl/my_processor_pkg.sv
// Shared types and constants for the fixed-point to half-precision converter.
// Latency: n/a (declarations only). Backpressure: n/a.
// Holds the FSM encoding, memory map, field widths and the leading-zero helper.
package my_processor_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_NORM,
        S_ST_LO,
        S_ST_HI,
        S_DONE
    } state_t;

    localparam logic [7:0] ADDR_IN_LO  = 8'd0;
    localparam logic [7:0] ADDR_IN_HI  = 8'd1;
    localparam logic [7:0] ADDR_OUT_LO = 8'd2;
    localparam logic [7:0] ADDR_OUT_HI = 8'd3;

    localparam int MAG_W = 15;
    localparam int EXP_W = 5;
    localparam int MAN_W = 10;

    localparam logic [EXP_W-1:0] EXP_INIT = 5'd21;

    // Zeros above the highest set bit of a 15-bit magnitude; 0 for an all-zero input.
    function automatic logic [3:0] lead_zeros(input logic [MAG_W-1:0] v);
        lead_zeros = 4'd0;
        for (int i = 0; i < MAG_W; i++) begin
            if (v[i]) lead_zeros = 4'(MAG_W - 1 - i);
        end
    endfunction

endpackage

// File: rtl/my_processor_data_mem.sv
// 256x8 private data memory: combinational 16-bit little-endian read, one byte write port.
// Latency: read 0 cycles, write lands on the next rising edge.
// Backpressure: none; contents are not reset.
module data_mem (
    input  logic        clk,
    input  logic        we,
    input  logic [7:0]  waddr,
    input  logic [7:0]  wdata,
    input  logic [7:0]  raddr,
    output logic [15:0] rdata
);

    logic [7:0] my_memory [0:255];

    // Plain always so the array can also be preloaded and inspected from outside.
    always @(posedge clk) begin
        if (we) my_memory[waddr] <= wdata;
    end

    assign rdata = {my_memory[raddr + 8'd1], my_memory[raddr]};

endmodule

// File: rtl/my_processor.sv
// Sign-magnitude Q7.8 to IEEE-754 half converter (truncating), operand at bytes 0-1, result at 2-3.
// Latency: 4+k cycles from accepted start to done (fixed 5 with FIX2FLT_FAST_NORM_EN defined).
// Backpressure: start is only honoured in IDLE and DONE; done holds until the next start or reset.
module my_processor
    import my_processor_pkg::*;
(
    input  logic clk,
    input  logic reset,
    input  logic start,
    output logic done
);

    state_t            state;
    logic              sign_r;
    logic [MAG_W-1:0]  mag_r;
    logic [EXP_W-1:0]  exp_r;

    logic [15:0]       mem_rd;
    logic [15:0]       result;
    logic              mem_we;
    logic [7:0]        mem_waddr;
    logic [7:0]        mem_wdata;

`ifdef FIX2FLT_FAST_NORM_EN
    logic [3:0]        lz;
    assign lz = lead_zeros(mag_r);
`endif

    // A zero magnitude bypasses packing so signed zero passes through untouched.
    assign result = (mag_r == '0) ? {sign_r, 15'd0}
                                  : {sign_r, exp_r, mag_r[MAG_W-2 -: MAN_W]};

    always_comb begin
        mem_we    = 1'b0;
        mem_waddr = ADDR_OUT_LO;
        mem_wdata = result[7:0];
        if (state == S_ST_LO) begin
            mem_we = 1'b1;
        end else if (state == S_ST_HI) begin
            mem_we    = 1'b1;
            mem_waddr = ADDR_OUT_HI;
            mem_wdata = result[15:8];
        end
    end

    data_mem dm1 (
        .clk   (clk),
        .we    (mem_we),
        .waddr (mem_waddr),
        .wdata (mem_wdata),
        .raddr (ADDR_IN_LO),
        .rdata (mem_rd)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_IDLE;
            done  <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) state <= S_LOAD;
                end
                S_LOAD: begin
                    sign_r <= mem_rd[15];
                    mag_r  <= mem_rd[MAG_W-1:0];
                    exp_r  <= EXP_INIT;
`ifdef FIX2FLT_FAST_NORM_EN
                    state  <= S_NORM;
`else
                    if (!mem_rd[MAG_W-1] && (mem_rd[MAG_W-1:0] != '0)) state <= S_NORM;
                    else                                               state <= S_ST_LO;
`endif
                end
                S_NORM: begin
`ifdef FIX2FLT_FAST_NORM_EN
                    mag_r <= mag_r << lz;
                    exp_r <= EXP_INIT - {1'b0, lz};
                    state <= S_ST_LO;
`else
                    mag_r <= mag_r << 1;
                    exp_r <= exp_r - 5'd1;
                    // Leave once the bit about to become the leading one is set.
                    if (mag_r[MAG_W-2]) state <= S_ST_LO;
`endif
                end
                S_ST_LO: state <= S_ST_HI;
                S_ST_HI: begin
                    state <= S_DONE;
                    done  <= 1'b1;
                end
                S_DONE: begin
                    if (start) begin
                        state <= S_LOAD;
                        done  <= 1'b0;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_my_processor.sv
// Scoreboarded random/directed bench for my_processor against an arithmetic reference model.
module tb_my_processor;
    import my_processor_pkg::*;

    logic clk = 1'b0;
    logic reset;
    logic start;
    logic done;

    always #5 clk = ~clk;

    my_processor dut (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .done  (done)
    );

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [15:0] res;
        int          lat;
        int          t0;
        logic [15:0] op;
    } exp_t;

    exp_t       sb[$];
    logic [7:0] shadow [0:255];
    logic       prev_done = 1'b0;

    task automatic check(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: actual 0x%0h required 0x%0h (t=%0t)", name, act, req, $time);
        end
    endtask

    // Value is m/256; for 2^p <= m < 2^(p+1) the exponent is p-8+15 and the
    // fraction is the bits below the leading one scaled to 10 bits, truncated.
    function automatic int top_bit(input int m);
        int p = 0;
        while ((1 << (p + 1)) <= m) p++;
        return p;
    endfunction

    function automatic logic [15:0] ref_conv(input logic [15:0] x);
        int m = int'(x[14:0]);
        int p;
        if (m == 0) return x;
        p = top_bit(m);
        return {x[15], 5'(p + 7), 10'(((m - (1 << p)) << 10) >> p)};
    endfunction

    function automatic int ref_lat(input logic [15:0] x);
`ifdef FIX2FLT_FAST_NORM_EN
        return 5;
`else
        int m = int'(x[14:0]);
        if (m == 0) return 4;
        return 4 + (14 - top_bit(m));
`endif
    endfunction

    // Monitor: every rising done retires one expected result.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (done && !prev_done) begin
                if (sb.size() == 0) begin
                    check("unexpected_done", 1, 0);
                end else begin
                    e = sb.pop_front();
                    check($sformatf("result[op=%04h]", e.op),
                          int'({dut.dm1.my_memory[3], dut.dm1.my_memory[2]}), int'(e.res));
                    check($sformatf("latency[op=%04h]", e.op), cyc - e.t0, e.lat);
                end
            end
            prev_done = done;
        end
    end

    task automatic wait_done();
        int n = 0;
        while (!done && n < 40) begin
            @(negedge clk);
            n++;
        end
        if (!done) check("done_timeout", 0, 1);
        @(negedge clk);
    endtask

    task automatic run_op(input logic [15:0] x, input logic [15:0] exp_res, input bit glitch);
        logic was_done;
        @(negedge clk);
        was_done = done;
        dut.dm1.my_memory[0] = x[7:0];
        dut.dm1.my_memory[1] = x[15:8];
        sb.push_back('{exp_res, ref_lat(x), cyc, x});
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        if (was_done) check("done_fall", int'(done), 0);
        if (glitch) begin
            @(negedge clk);
            start = 1'b1;
            @(negedge clk);
            start = 1'b0;
        end
        wait_done();
    endtask

    logic [15:0] dir_op  [11] = '{16'h0000, 16'h8000, 16'h0001, 16'h8001, 16'h0003, 16'h000C,
                                  16'h7FFF, 16'hFFFF, 16'h4000, 16'hC000, 16'h1FFF};
    logic [15:0] dir_res [11] = '{16'h0000, 16'h8000, 16'h1C00, 16'h9C00, 16'h2200, 16'h2A00,
                                  16'h57FF, 16'hD7FF, 16'h5400, 16'hD400, 16'h4FFF};

    initial begin
        int bad;
        logic [15:0] x;
        reset = 1'b1;
        start = 1'b0;
        for (int i = 0; i < 256; i++) begin
            shadow[i] = 8'($urandom);
            dut.dm1.my_memory[i] = shadow[i];
        end
        repeat (2) @(negedge clk);
        check("reset_done", int'(done), 0);
        check("reset_state", int'(dut.state), int'(S_IDLE));
        reset = 1'b0;

        for (int i = 0; i < 11; i++) run_op(dir_op[i], dir_res[i], 1'b0);

        // start pulsed while the long normalization is in flight
        run_op(16'h0001, 16'h1C00, 1'b1);

        // reset in the middle of normalization
        @(negedge clk);
        dut.dm1.my_memory[0] = 8'h01;
        dut.dm1.my_memory[1] = 8'h00;
        dut.dm1.my_memory[2] = 8'hA5;
        dut.dm1.my_memory[3] = 8'h5A;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        check("pre_reset_state", int'(dut.state), int'(S_NORM));
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("midrst_done", int'(done), 0);
        check("midrst_state", int'(dut.state), int'(S_IDLE));
        @(negedge clk);
        check("midrst_lo", int'(dut.dm1.my_memory[2]), 'hA5);
        check("midrst_hi", int'(dut.dm1.my_memory[3]), 'h5A);
        run_op(16'h0001, 16'h1C00, 1'b0);

        // reset and start together: reset wins
        @(negedge clk);
        reset = 1'b1;
        start = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        start = 1'b0;
        check("rst_start_state", int'(dut.state), int'(S_IDLE));
        check("rst_start_done", int'(done), 0);
        @(negedge clk);
        check("rst_start_stay", int'(dut.state), int'(S_IDLE));

        for (int i = 0; i < 24; i++) begin
            x = 16'($urandom);
            if (i % 4 == 1) x = x & 16'h80FF;
            run_op(x, ref_conv(x), 1'b0);
        end

        repeat (3) @(negedge clk);
        check("sb_empty", sb.size(), 0);
        bad = 0;
        for (int i = 4; i < 256; i++) if (dut.dm1.my_memory[i] !== shadow[i]) bad++;
        check("untouched_bytes", bad, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, %0d checks, %0d errors", checks, errors);
        $fatal(1, "watchdog");
    end

endmodule
